qspi_data_ctrl: RTL and testbench
=================================

Name: qspi_data_ctrl

Overview:
- QSPI memory controller for the data port.
- Consumes the load/store requests from the data-access stage (d_read_*/d_write_*) and performs a serial-command, quad-address, quad-data transaction on an external QSPI PSRAM.
- Returns read_valid with raw little-endian read_data for loads, and write_finish for stores.
- Sign and zero extension are done by the data-access stage, not here.

Parameters:
ADR_W, 24, number of low address bits sent to the device; upper bits are ignored.
DUMMY_SCK, 6, dummy SCK cycles between address and read data.
OP_READ, 8'hEB, quad read opcode.
OP_WRITE, 8'h38, quad write opcode.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
d_read_req  in  1  load request, level, held until read_valid
d_read_w  in  1  word access
d_read_hw  in  1  halfword access; w=0 and hw=0 means byte
d_read_adr  in  32  load byte address
read_valid  out  1  one-cycle pulse; read_data is valid in the same cycle
read_data  out  32  first byte in [7:0], then upward; unused upper bytes are 0
d_write_req  in  1  store request, level, held until write_finish
d_write_w  in  1  word store
d_write_hw  in  1  halfword store
d_write_adr  in  32  store byte address
d_write_data  in  32  store data; byte 0 is [7:0]
write_finish  out  1  one-cycle completion pulse
busy  out  1  high whenever state is not IDLE
qspi_sck  out  1  serial clock, clk/2
qspi_cs_n  out  1  chip select, active-low
qspi_dout  out  4  io[3:0] output values
qspi_doe  out  4  io[3:0] output enables
qspi_din  in  4  io[3:0] input values

Behaviour:
- Reset values: all outputs 0 except qspi_cs_n=1; state=IDLE; read_data=0.
- Reset asserted mid-transaction aborts immediately: cs_n=1, sck=0, doe=0, no completion pulse.
- States: IDLE, CMD, ADR, DMY, RDAT, WDAT, FIN.
- IDLE:
  - Samples requests every cycle. d_read_req has priority over d_write_req when both are high.
  - On accept, latch the operation, adr[ADR_W-1:0], the nibble count (byte=2, hw=4, word=8) and the write data. Next state is CMD.
- SCK generation:
  - A phase bit ph toggles every clk in CMD through RDAT/WDAT; qspi_sck=ph, and sck=0 in IDLE and FIN.
  - One SCK period is 2 clk. Output values change only in the clk where ph=0 (SCK low).
  - Input nibbles are captured at the clk edge that ends ph=1 (falling SCK).
- CMD: cs_n=0. Opcode sent MSB-first on io0, doe=4'b0001, for 8 SCK (16 clk). Next state is ADR.
- ADR: doe=4'hF. Address sent as 6 nibbles, MSB nibble first (12 clk). Next state is DMY for a read, WDAT for a write.
- DMY: doe=0 for DUMMY_SCK SCK (12 clk). Next state is RDAT.
- RDAT: doe=0. Nibbles are captured byte by byte, high nibble first.
  - Byte k is written to read_data[8k+7:8k].
  - Byte lanes not read are cleared at accept.
  - Next state is FIN after the last nibble.
- WDAT: doe=4'hF. Bytes are sent from byte 0 upward, high nibble first. Next state is FIN after the last nibble.
- FIN (1 clk):
  - cs_n=1, doe=0.
  - Pulse read_valid or write_finish according to the operation.
  - Next state is IDLE.
- cs_n is therefore high for at least 2 clk (FIN + IDLE) between transactions.
- read_data holds its value until the next read accept. Writes never change it.
- Latency from an IDLE cycle T with the request high to the FIN cycle:
  - read: T+41+2n
  - write: T+29+2n
  - n = nibble count. Word read T+57, byte read T+45, word write T+45, hw write T+37, byte write T+33.
- Requests seen outside IDLE are ignored. The requester deasserts the request in the cycle after the completion pulse unless it is issuing a new one. A request still high in the IDLE cycle after FIN is treated as a new transaction.
- Width changes or address bits above ADR_W never cause an error.

Decomposition:
- Shared include qspi_defs holds:
  - state encodings (3-bit `define)
  - default opcodes
  - nibble-count constants
- Natural sub-module qspi_nibble_shifter:
  - 32-bit shift register with load, shift-out-nibble, shift-in-nibble and byte-order handling.
  - Used for command, address and data.

Test Plan:
- Word read, adr 0x8000_0100, device returns bytes 11 22 33 44: io0 carries 0xEB; address nibbles 0,0,0,1,0,0; read_valid at T+57 with read_data=0x44332211; busy low at T+58.
- Halfword write, adr 0x10, data 0xABCD1234: address nibbles 000010, data nibbles 3,4,1,2; write_finish at T+37; read_data unchanged.
- Byte read returning 0xF0 → read_data=0x000000F0 at T+45, upper bytes zero despite a prior word read of 0xFFFFFFFF.
- d_read_req and d_write_req high together → read performed first (opcode 0xEB); the write starts in the IDLE cycle after FIN and cs_n is high ≥2 clk between them.
- rst pulsed during ADR → same cycle cs_n=1, sck=0, doe=0; no read_valid; the next request completes normally.
- Back-to-back word reads with the request held continuously → read_valid at T+57, second read_valid 58 clk later; no lost or duplicated pulse.

Source files
------------

// File: rtl/qspi_data_ctrl_pkg.sv
// Shared types and constants for the QSPI data-port controller.
// State encoding, default opcodes, nibble counts per access width, byte-order helper.
package qspi_data_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADR  = 3'd2,
        S_DMY  = 3'd3,
        S_RDAT = 3'd4,
        S_WDAT = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam logic [7:0] DEF_OP_READ  = 8'hEB;
    localparam logic [7:0] DEF_OP_WRITE = 8'h38;

    localparam logic [3:0] NIB_BYTE = 4'd2;
    localparam logic [3:0] NIB_HW   = 4'd4;
    localparam logic [3:0] NIB_WORD = 4'd8;

    localparam int CMD_BITS = 8;

    function automatic logic [3:0] nib_count(input logic w, input logic hw);
        if (w)
            return NIB_WORD;
        else if (hw)
            return NIB_HW;
        return NIB_BYTE;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/qspi_data_ctrl_shifter.sv
// 32-bit MSB-first shifter shared by opcode (bit), address/data (nibble) and read capture.
// Loading with swap puts byte 0 at the top so stores go out byte 0 first.
module qspi_nibble_shifter
    import qspi_data_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        swap,
    input  logic [31:0] load_data,
    input  logic        shift_bit,
    input  logic        shift_nib,
    input  logic [3:0]  nib_in,
    output logic        msb,
    output logic [3:0]  msb_nib,
    output logic [3:0]  lsb_nib
);

    logic [31:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 32'h0;
        end else if (load) begin
            q <= swap ? byte_swap(load_data) : load_data;
        end else if (shift_nib) begin
            q <= {q[27:0], nib_in};
        end else if (shift_bit) begin
            q <= {q[30:0], 1'b0};
        end
    end

    assign msb     = q[31];
    assign msb_nib = q[31:28];
    assign lsb_nib = q[3:0];

endmodule

// File: rtl/qspi_data_ctrl.sv
// QSPI PSRAM controller for the data port: serial opcode, quad address, quad data.
// SCK = clk/2; outputs change while SCK is low, inputs are captured at falling SCK.
module qspi_data_ctrl
    import qspi_data_ctrl_pkg::*;
#(
    parameter int          ADR_W     = 24,
    parameter int          DUMMY_SCK = 6,
    parameter logic [7:0]  OP_READ   = DEF_OP_READ,
    parameter logic [7:0]  OP_WRITE  = DEF_OP_WRITE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_read_req,
    input  logic        d_read_w,
    input  logic        d_read_hw,
    input  logic [31:0] d_read_adr,
    output logic        read_valid,
    output logic [31:0] read_data,
    input  logic        d_write_req,
    input  logic        d_write_w,
    input  logic        d_write_hw,
    input  logic [31:0] d_write_adr,
    input  logic [31:0] d_write_data,
    output logic        write_finish,
    output logic        busy,
    output logic        qspi_sck,
    output logic        qspi_cs_n,
    output logic [3:0]  qspi_dout,
    output logic [3:0]  qspi_doe,
    input  logic [3:0]  qspi_din
);

    localparam int ADR_NIBS = ADR_W / 4;

    state_t      state, state_nxt;
    logic        ph;
    logic [7:0]  cnt;
    logic [7:0]  limit;
    logic        step_end;
    logic        accept;
    logic        op_rd;
    logic [31:0] adr_q;
    logic [31:0] wdat_q;
    logic [3:0]  nib_n;

    logic        sh_load;
    logic        sh_swap;
    logic [31:0] sh_load_data;
    logic        sh_shift_bit;
    logic        sh_shift_nib;
    logic [3:0]  sh_nib_in;
    logic        sh_msb;
    logic [3:0]  sh_msb_nib;
    logic [3:0]  sh_lsb_nib;

    qspi_nibble_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .swap      (sh_swap),
        .load_data (sh_load_data),
        .shift_bit (sh_shift_bit),
        .shift_nib (sh_shift_nib),
        .nib_in    (sh_nib_in),
        .msb       (sh_msb),
        .msb_nib   (sh_msb_nib),
        .lsb_nib   (sh_lsb_nib)
    );

    // cnt counts SCK periods inside the current phase; it advances at falling SCK
    always_comb begin
        limit = {4'b0, nib_n};
        case (state)
            S_CMD:   limit = 8'(CMD_BITS);
            S_ADR:   limit = 8'(ADR_NIBS);
            S_DMY:   limit = 8'(DUMMY_SCK);
            default: limit = {4'b0, nib_n};
        endcase
    end

    assign step_end = ph && (cnt == limit - 8'd1);
    assign accept   = (state == S_IDLE) && (d_read_req || d_write_req);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        qspi_cs_n    = 1'b1;
        qspi_sck     = 1'b0;
        qspi_dout    = 4'h0;
        qspi_doe     = 4'h0;
        read_valid   = 1'b0;
        write_finish = 1'b0;
        sh_load      = 1'b0;
        sh_swap      = 1'b0;
        sh_load_data = 32'h0;
        sh_shift_bit = 1'b0;
        sh_shift_nib = 1'b0;
        sh_nib_in    = 4'h0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt    = S_CMD;
                    sh_load      = 1'b1;
                    sh_load_data = {(d_read_req ? OP_READ : OP_WRITE), 24'h0};
                end
            end
            S_CMD: begin
                qspi_cs_n    = 1'b0;
                qspi_sck     = ph;
                qspi_doe     = 4'b0001;
                qspi_dout    = {3'b000, sh_msb};
                sh_shift_bit = ph;
                if (step_end) begin
                    state_nxt    = S_ADR;
                    sh_load      = 1'b1;
                    sh_load_data = adr_q << (32 - ADR_W);
                end
            end
            S_ADR: begin
                qspi_cs_n    = 1'b0;
                qspi_sck     = ph;
                qspi_doe     = 4'hF;
                qspi_dout    = sh_msb_nib;
                sh_shift_nib = ph;
                if (step_end) begin
                    if (op_rd) begin
                        state_nxt = S_DMY;
                    end else begin
                        state_nxt    = S_WDAT;
                        sh_load      = 1'b1;
                        sh_swap      = 1'b1;
                        sh_load_data = wdat_q;
                    end
                end
            end
            S_DMY: begin
                qspi_cs_n = 1'b0;
                qspi_sck  = ph;
                if (step_end)
                    state_nxt = S_RDAT;
            end
            S_RDAT: begin
                qspi_cs_n    = 1'b0;
                qspi_sck     = ph;
                sh_shift_nib = ph;
                sh_nib_in    = qspi_din;
                if (step_end)
                    state_nxt = S_FIN;
            end
            S_WDAT: begin
                qspi_cs_n    = 1'b0;
                qspi_sck     = ph;
                qspi_doe     = 4'hF;
                qspi_dout    = sh_msb_nib;
                sh_shift_nib = ph;
                if (step_end)
                    state_nxt = S_FIN;
            end
            S_FIN: begin
                read_valid   = op_rd;
                write_finish = ~op_rd;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph        <= 1'b0;
            cnt       <= 8'd0;
            op_rd     <= 1'b0;
            adr_q     <= 32'h0;
            wdat_q    <= 32'h0;
            nib_n     <= 4'd0;
            read_data <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    ph  <= 1'b0;
                    cnt <= 8'd0;
                    if (accept) begin
                        op_rd  <= d_read_req;
                        adr_q  <= d_read_req ? d_read_adr : d_write_adr;
                        nib_n  <= d_read_req ? nib_count(d_read_w, d_read_hw)
                                             : nib_count(d_write_w, d_write_hw);
                        wdat_q <= d_write_data;
                        if (d_read_req)
                            read_data <= 32'h0;
                    end
                end
                S_FIN: begin
                    ph  <= 1'b0;
                    cnt <= 8'd0;
                end
                default: begin
                    ph <= ~ph;
                    if (ph)
                        cnt <= step_end ? 8'd0 : cnt + 8'd1;
                    // odd nibble completes a byte: high half already sits in the shifter
                    if (state == S_RDAT && ph && cnt[0])
                        read_data[{cnt[2:1], 3'b000} +: 8] <= {sh_lsb_nib, qspi_din};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_data_ctrl.sv
// Directed bench for qspi_data_ctrl with a behavioural QSPI PSRAM on the bus.
// Table of single transactions plus hand sequences for priority, abort and back-to-back.
module tb_qspi_data_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_read_req = 1'b0, d_read_w = 1'b0, d_read_hw = 1'b0;
    logic [31:0] d_read_adr = 32'h0;
    logic        d_write_req = 1'b0, d_write_w = 1'b0, d_write_hw = 1'b0;
    logic [31:0] d_write_adr = 32'h0, d_write_data = 32'h0;
    logic        read_valid, write_finish, busy;
    logic [31:0] read_data;
    logic        qspi_sck, qspi_cs_n;
    logic [3:0]  qspi_dout, qspi_doe;
    logic [3:0]  qspi_din = 4'h0;

    qspi_data_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .d_read_req   (d_read_req),
        .d_read_w     (d_read_w),
        .d_read_hw    (d_read_hw),
        .d_read_adr   (d_read_adr),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .d_write_req  (d_write_req),
        .d_write_w    (d_write_w),
        .d_write_hw   (d_write_hw),
        .d_write_adr  (d_write_adr),
        .d_write_data (d_write_data),
        .write_finish (write_finish),
        .busy         (busy),
        .qspi_sck     (qspi_sck),
        .qspi_cs_n    (qspi_cs_n),
        .qspi_dout    (qspi_dout),
        .qspi_doe     (qspi_doe),
        .qspi_din     (qspi_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        w;
        logic        hw;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] dev;      // bytes the device returns, byte 0 in [7:0]
        int          lat;
        logic [23:0] exp_adr;
        logic [31:0] exp_val;  // read_data for reads, nibble stream for writes
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd_model = 32'h0;

    // device model: counts SCK-high cycles, records opcode/address/write nibbles, drives read data
    logic [31:0] dev_word = 32'h0;
    logic [7:0]  mon_op = 8'h0;
    logic [23:0] mon_adr = 24'h0;
    logic [31:0] mon_wdat = 32'h0;
    int          edge_cnt = 0;
    int          doe_err = 0;

    always @(negedge clk) begin
        if (qspi_cs_n) begin
            edge_cnt = 0;
        end else if (qspi_sck) begin
            logic [3:0] exp_doe;
            logic [7:0] b;
            int idx;
            if (edge_cnt == 0) begin
                mon_op = 8'h0; mon_adr = 24'h0; mon_wdat = 32'h0;
            end
            if (edge_cnt < 8) begin
                exp_doe = 4'b0001;
                mon_op  = {mon_op[6:0], qspi_dout[0]};
            end else if (edge_cnt < 14) begin
                exp_doe = 4'hF;
                mon_adr = {mon_adr[19:0], qspi_dout};
            end else if (mon_op == 8'h38) begin
                exp_doe  = 4'hF;
                mon_wdat = {mon_wdat[27:0], qspi_dout};
            end else begin
                exp_doe = 4'h0;
                if (edge_cnt >= 20) begin
                    idx = edge_cnt - 20;
                    b = 8'(dev_word >> (8 * (idx / 2)));
                    qspi_din = (idx % 2 == 1) ? b[3:0] : b[7:4];
                end
            end
            if (qspi_doe !== exp_doe) doe_err = doe_err + 1;
            edge_cnt = edge_cnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if (v.wr) begin
            d_write_req = 1'b1; d_write_w = v.w; d_write_hw = v.hw;
            d_write_adr = v.adr; d_write_data = v.wdata;
        end else begin
            d_read_req = 1'b1; d_read_w = v.w; d_read_hw = v.hw; d_read_adr = v.adr;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k, bad, doe_base;
        logic [31:0] got;
        k = -1; bad = 0; got = 32'h0;
        dev_word = v.dev;
        doe_base = doe_err;
        @(negedge clk);
        drive(v);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (v.wr ? read_valid : write_finish) bad++;
            if (v.wr ? write_finish : read_valid) begin
                k = c; got = read_data; break;
            end
        end
        d_read_req = 1'b0; d_write_req = 1'b0;
        check("latency", k, v.lat);
        check("opcode", {24'h0, mon_op}, v.wr ? 32'h38 : 32'hEB);
        check("address", {8'h0, mon_adr}, {8'h0, v.exp_adr});
        if (v.wr) begin
            check("write_nibbles", mon_wdat, v.exp_val);
            check("rdata_kept", got, rd_model);
        end else begin
            check("read_data", got, v.exp_val);
            rd_model = v.exp_val;
        end
        check("wrong_pulse", bad, 0);
        check("doe_pattern", doe_err - doe_base, 0);
        @(negedge clk);
        check("idle_after", {30'h0, busy, qspi_cs_n}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        int k, k2, bad, hi, pulses;
        logic [31:0] got;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0,          32'h4433_2211, 57, 24'h000100, 32'h4433_2211};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hABCD_1234,  32'h0,         37, 24'h000010, 32'h0000_3412};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hFFFF_FFFF, 57, 24'h000020, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hAB12_3456, 32'h0,          32'h9988_77F0, 45, 24'h123456, 32'h0000_00F0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h00AB_CDEF, 32'h1122_3344,  32'h0,         45, 24'hABCDEF, 32'h4433_2211};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h1234_56A5,  32'h0,         33, 24'h000005, 32'h0000_00A5};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0F0E, 32'h0,          32'h1111_C35A, 49, 24'h000F0E, 32'h0000_C35A};

        repeat (3) @(negedge clk);
        check("reset_pins", {22'h0, qspi_cs_n, qspi_sck, qspi_doe, qspi_dout},
              {22'h0, 1'b1, 1'b0, 4'h0, 4'h0});
        check("reset_flags", {29'h0, busy, read_valid, write_finish}, 32'h0);
        check("reset_rdata", read_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // simultaneous requests: read first, then write after a cs_n gap
        dev_word = 32'h4433_2211;
        @(negedge clk);
        d_read_req = 1'b1;  d_read_w = 1'b1;  d_read_hw = 1'b0;  d_read_adr = 32'h100;
        d_write_req = 1'b1; d_write_w = 1'b1; d_write_hw = 1'b0; d_write_adr = 32'h200;
        d_write_data = 32'hCAFE_F00D;
        k = -1; bad = 0; got = 32'h0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (write_finish) bad++;
            if (read_valid) begin k = c; got = read_data; break; end
        end
        d_read_req = 1'b0;
        check("both_read_lat", k, 57);
        check("both_read_op", {24'h0, mon_op}, 32'hEB);
        check("both_read_data", got, 32'h4433_2211);
        rd_model = 32'h4433_2211;
        hi = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (qspi_cs_n) hi++; else break;
        end
        check("cs_gap_ge2", {31'h0, hi >= 2}, 32'h1);
        k = -1;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (read_valid) bad++;
            if (write_finish) begin k = c; got = read_data; break; end
        end
        d_write_req = 1'b0;
        check("both_write_lat", k, 45);
        check("both_write_op", {24'h0, mon_op}, 32'h38);
        check("both_write_adr", {8'h0, mon_adr}, 32'h200);
        check("both_write_data", mon_wdat, 32'h0DF0_FECA);
        check("both_rdata_kept", got, rd_model);
        check("both_wrong_pulse", bad, 0);

        // reset during the address phase aborts immediately
        @(negedge clk);
        d_read_req = 1'b1; d_read_w = 1'b1; d_read_hw = 1'b0; d_read_adr = 32'h40;
        repeat (20) @(negedge clk);
        check("pre_abort", {26'h0, busy, qspi_cs_n, qspi_doe}, {26'h0, 1'b1, 1'b0, 4'hF});
        rst = 1'b1;
        #1;
        check("abort_pins", {24'h0, qspi_cs_n, qspi_sck, qspi_doe, busy, read_valid},
              {24'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
        d_read_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            pulses += int'(read_valid) + int'(write_finish);
        end
        check("no_pulse_after_abort", pulses, 0);
        check("abort_rdata_cleared", read_data, 32'h0);
        rd_model = 32'h0;
        run_vec(vecs[0]);

        // back-to-back reads with the request held
        dev_word = 32'h5566_7788;
        @(negedge clk);
        d_read_req = 1'b1; d_read_w = 1'b1; d_read_hw = 1'b0; d_read_adr = 32'h300;
        k = -1; k2 = -1; got = 32'h0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (read_valid) begin k = c; break; end
        end
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (read_valid) begin k2 = c; got = read_data; break; end
        end
        d_read_req = 1'b0;
        check("b2b_first_lat", k, 57);
        check("b2b_second_gap", k2, 58);
        check("b2b_data", got, 32'h5566_7788);
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            pulses += int'(read_valid) + int'(write_finish);
        end
        check("b2b_no_extra", pulses, 0);
        check("b2b_idle", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
